// File: rtl/sort_mem.sv
// sort_mem: 8x8 word store that runs LOAD -> SORT -> DUMP around an external in-place sort controller.
// Latency: sorter read is combinational, sorter write is visible the next cycle; sort_go follows the last load by 1 cycle; dump starts the cycle after sort_done.
// Backpressure: load via in_valid/in_ready; the dump word is held on out_data while out_ready is low. Optional SORT_MEM_CHECK_EN builds the sticky dump-order checker.
module sort_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  input  logic          s_wr,
  output logic [DW-1:0] s_rdata,
  output logic          sort_go,
  input  logic          sort_done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          order_err
);

  typedef enum logic [1:0] {LOAD, SORT, DUMP} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          sort_go_nxt;
  logic [DW-1:0] mem [DEPTH];

  // Both ports read the array without a register stage.
  assign s_rdata  = mem[s_addr];
  assign out_data = mem[ptr];

  // Next-state, pointer and handshake outputs; ptr wraps naturally modulo DEPTH.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sort_go_nxt = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ptr_nxt = ptr + AW'(1);
          if (ptr == LAST) begin
            state_nxt   = SORT;
            sort_go_nxt = 1'b1;
          end
        end
      end
      SORT: begin
        if (sort_done) begin
          state_nxt = DUMP;
          ptr_nxt   = '0;
        end
      end
      DUMP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ptr_nxt = ptr + AW'(1);
          if (ptr == LAST) state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
        ptr_nxt   = '0;
      end
    endcase
  end

  // State, pointer, start pulse and busy flag; busy tracks the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD;
      ptr     <= '0;
      sort_go <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      sort_go <= sort_go_nxt;
      busy    <= (state_nxt != LOAD);
    end
  end

  // Array writes: host load in LOAD, sorter write in SORT; contents are not reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem[ptr] <= in_data;
    end else if (state == SORT && s_wr) begin
      mem[s_addr] <= s_wdata;
    end
  end

`ifdef SORT_MEM_CHECK_EN
  logic [DW-1:0] prev_dat;

  // Sticky flag when an accepted dump word is smaller than the one before it in the same dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_dat  <= '0;
      order_err <= 1'b0;
    end else if (state == DUMP && out_ready) begin
      prev_dat <= out_data;
      if (ptr != '0 && out_data < prev_dat) order_err <= 1'b1;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: doc/sort_mem.md
# sort_mem

Memory responder for the in-place sorter: an 8×8 word store that answers the sorting datapath's address/read/write port and gives a host streaming load and dump access. The block owns the LOAD → SORT → DUMP sequence. It accepts DEPTH words from the host, pulses the sort controller to start, yields the memory to the sorter until the controller reports done, then streams the sorted contents back out.

## Interface
- DEPTH, 8: number of words; a power of two.
- AW, 3: address width, log2(DEPTH).
- DW, 8: word width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- s_addr  in  AW  sorter address (datapath Addr).
- s_wdata  in  DW  sorter write data (datapath Dout).
- s_wr  in  1  sorter write strobe.
- s_rdata  out  DW  combinational read data, mem[s_addr] (datapath Din).
- sort_go  out  1  one-cycle start pulse to the sort controller.
- sort_done  in  1  controller completion pulse.
- in_valid  in  1  host load data valid.
- in_ready  out  1  block can accept a load word.
- in_data  in  DW  load word.
- out_valid  out  1  dump word valid.
- out_ready  in  1  host accepts the dump word.
- out_data  out  DW  dump word.
- busy  out  1  high in SORT and DUMP.
- order_err  out  1  sticky: dump stream was not non-decreasing.

## Operation
- FSM states: LOAD, SORT, DUMP. Reset state is LOAD. Pointer ptr is AW bits wide and resets to 0.
- **LOAD**
  - in_ready = 1.
  - On in_valid && in_ready: mem[ptr] ← in_data and ptr increments.
  - When the word at ptr = DEPTH-1 is accepted: ptr wraps to 0, state → SORT, and the sort_go register is set.
- **SORT**
  - sort_go is high in the first SORT cycle only.
  - s_wr writes mem[s_addr] ← s_wdata at the clock edge.
  - sort_done → DUMP with ptr = 0.
  - sort_done in the same cycle as sort_go is legal and honoured.
- **DUMP**
  - out_valid = 1 and out_data = mem[ptr].
  - On out_valid && out_ready: ptr increments.
  - After the word at DEPTH-1 is accepted: ptr = 0, state → LOAD.
- s_rdata = mem[s_addr] in every state, with no latency.
- Ignored conditions:
  - s_wr outside SORT.
  - sort_done outside SORT.
  - in_valid outside LOAD (in_ready is 0).
- Unsigned DW-bit data; no arithmetic beyond the ptr increment, which is modulo DEPTH.
- Reset mid-operation: state → LOAD, ptr = 0, all outputs return to their reset values. The memory array is not reset and its contents are undefined until reloaded.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, sort_go = 0, busy = 0, order_err = 0.
  - s_rdata follows the array and is unspecified after reset.
- Load: one word per cycle at full rate; DEPTH handshakes minimum.
- sort_go asserts in the cycle after the final load handshake and lasts exactly 1 cycle.
- Sorter read: combinational. Sorter write: visible on s_rdata the cycle after the edge.
- DUMP is entered the cycle after sort_done. out_valid rises that cycle, so there is zero bubble.
- out_data stays stable while out_valid && !out_ready.
- Dump rate is one word per cycle under continuous out_ready. in_ready rises the cycle after the final dump handshake.
- busy is registered from state.

## Configuration
- SORT_MEM_CHECK_EN defined:
  - During DUMP, each accepted word is compared with the previously accepted word of the same dump.
  - If the new word is smaller, order_err is set the next cycle.
  - order_err stays set until reset; a new LOAD does not clear it.
- Undefined: order_err is tied to 0 and no comparator or previous-word register is built.

## Test plan
- **Basic pass:**
  - Reset, then load 5,3,7,1,0,6,2,4 back-to-back.
  - Expect sort_go high exactly 1 cycle, 1 cycle after the 8th handshake, and in_ready = 0 from then on.
  - With no s_wr, pulse sort_done; expect the dump to return 5,3,7,1,0,6,2,4.
- **Sorter port:**
  - In SORT, drive s_addr = 2, s_wdata = 0xAA, s_wr = 1.
  - Expect s_rdata = 0xAA at address 2 the next cycle. Dump word 2 = 0xAA.
  - s_wr issued in LOAD changes nothing.
- **Backpressure:**
  - During DUMP, toggle out_ready 1,0,0,1,…
  - Expect each word to be held stable and emitted once, 8 words total, then state LOAD.
- **Order check (macro on):**
  - Load ascending 0–7 with no writes; expect order_err = 0.
  - Reload 1,0,2..7 with no writes; expect order_err = 1 one cycle after word 1 is accepted, still 1 after the next load.
  - With the macro off, order_err = 0 throughout.
- **Reset mid-dump:**
  - Assert rst low after 3 dump words.
  - Expect out_valid = 0 immediately and busy = 0. After release, in_ready = 1 and ptr restarts at 0: a new load of 8 words is accepted.
- **Early/late done:**
  - sort_done pulsed in LOAD is ignored.
  - sort_done coincident with sort_go enters DUMP the next cycle.
